// File: rtl/ga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ga_pkg
// Description : Shared types and helpers for the GA offspring datapath:
//               FSM state encoding, chromosome width, crossover mask and
//               single-bit mutation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ga_pkg;

    localparam int CHROM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CROSS  = 2'd1,
        ST_MUTATE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Low k bits set: bits below the cut point come from parent A.
    function automatic logic [CHROM_W-1:0] xover_mask(input logic [2:0] k);
        return (CHROM_W'(1) << k) - CHROM_W'(1);
    endfunction

    // Invert exactly one chromosome bit at position pos.
    function automatic logic [CHROM_W-1:0] mut_flip(input logic [CHROM_W-1:0] chrom,
                                                    input logic [2:0]         pos);
        return chrom ^ (CHROM_W'(1) << pos);
    endfunction

endpackage : ga_pkg
`default_nettype wire

// File: rtl/ga_breeder.sv
`default_nettype none
// ============================================================================
// Module      : ga_breeder
// Description : Offspring generator. Accepts two parent chromosomes, applies
//               single-point crossover and probabilistic single-bit mutation
//               using two consecutive LFSR bytes, then presents the child
//               over a valid/ready handshake and counts delivered children.
// Revision    : 1.0 - initial release
// ============================================================================
module ga_breeder
    import ga_pkg::*;
#(
    parameter logic [3:0] MUT_THRESH = 4'd2,
    parameter int         CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rand_in,
    input  logic [CHROM_W-1:0]  parent_a,
    input  logic [CHROM_W-1:0]  parent_b,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CHROM_W-1:0]  child,
    output logic                mut_flag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    child_cnt
);

    state_t              r_state;
    logic [CHROM_W-1:0]  r_parent_a;
    logic [CHROM_W-1:0]  r_parent_b;
    logic [CHROM_W-1:0]  r_xover;
    logic [CHROM_W-1:0]  r_child;
    logic                r_mut_flag;
    logic                r_out_valid;
    logic [CNT_W-1:0]    r_child_cnt;

    logic [CHROM_W-1:0]  w_mask;
    logic                w_do_mut;
    logic                w_unused_rand;

    // Bit 3 of the random byte plays no role in either stage.
    assign w_unused_rand = rand_in[3];

    // Cut point and mutation decision, taken from the byte present in the
    // current cycle (CROSS uses it for k, MUTATE for the flip decision).
    assign w_mask   = xover_mask(rand_in[2:0]);
    assign w_do_mut = (rand_in[7:4] < MUT_THRESH);

    // Ready only while idle, and never while reset is asserted.
    assign in_ready = (r_state == ST_IDLE) && !rst;

    // Single FSM sequencing accept -> crossover -> mutation -> delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_parent_a  <= '0;
            r_parent_b  <= '0;
            r_xover     <= '0;
            r_child     <= '0;
            r_mut_flag  <= 1'b0;
            r_out_valid <= 1'b0;
            r_child_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_parent_a <= parent_a;
                        r_parent_b <= parent_b;
                        r_state    <= ST_CROSS;
                    end
                end
                ST_CROSS: begin
                    // Held in a separate register so the delivered child stays
                    // visible until the mutation edge overwrites it.
                    r_xover <= (r_parent_a & w_mask) | (r_parent_b & ~w_mask);
                    r_state <= ST_MUTATE;
                end
                ST_MUTATE: begin
                    if (w_do_mut) begin
                        r_child    <= mut_flip(r_xover, rand_in[2:0]);
                        r_mut_flag <= 1'b1;
                    end else begin
                        r_child    <= r_xover;
                        r_mut_flag <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_child_cnt <= r_child_cnt + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign child     = r_child;
    assign mut_flag  = r_mut_flag;
    assign out_valid = r_out_valid;
    assign child_cnt = r_child_cnt;

endmodule : ga_breeder
`default_nettype wire

// File: tb/tb_ga_breeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ga_breeder
// Description : Self-checking bench for ga_breeder. Two instances share the
//               stimulus: one with default parameters, one with a 2-bit
//               counter and mutation disabled. Expected children come from a
//               bit-by-bit crossover/mutation reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ga_breeder;

    localparam logic [3:0] C_THRESH_A = 4'd2;
    localparam logic [3:0] C_THRESH_B = 4'd0;

    logic        clk;
    logic        rst;
    logic [7:0]  rand_in;
    logic [7:0]  parent_a;
    logic [7:0]  parent_b;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic [7:0]  child_a,     child_b;
    logic        mut_flag_a,  mut_flag_b;
    logic        out_valid_a, out_valid_b;
    logic [15:0] child_cnt_a;
    logic [1:0]  child_cnt_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_cnt_a;
    logic [1:0]  exp_cnt_b;

    ga_breeder #(.MUT_THRESH(C_THRESH_A), .CNT_W(16)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .rand_in   (rand_in),
        .parent_a  (parent_a),
        .parent_b  (parent_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .child     (child_a),
        .mut_flag  (mut_flag_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .child_cnt (child_cnt_a)
    );

    ga_breeder #(.MUT_THRESH(C_THRESH_B), .CNT_W(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .rand_in   (rand_in),
        .parent_a  (parent_a),
        .parent_b  (parent_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .child     (child_b),
        .mut_flag  (mut_flag_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .child_cnt (child_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bits below the cut come from A, the rest from B; a mutation
    // inverts one bit when the draw's high nibble is below the threshold.
    function automatic logic [7:0] ref_child(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] rc, input logic [7:0] rm,
                                             input logic [3:0] thresh, output logic mut);
        logic [7:0] c;
        int k;
        int p;
        k = int'(rc[2:0]);
        for (int i = 0; i < 8; i++) c[i] = (i < k) ? a[i] : b[i];
        mut = (int'(rm[7:4]) < int'(thresh));
        if (mut) begin
            p = int'(rm[2:0]);
            c[p] = ~c[p];
        end
        return c;
    endfunction

    // One full transaction starting one step after an edge with both DUTs idle.
    task automatic run_child(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] rc, input logic [7:0] rm, input int hold);
        logic [7:0] e_a, e_b;
        logic       m_a, m_b;
        e_a = ref_child(a, b, rc, rm, C_THRESH_A, m_a);
        e_b = ref_child(a, b, rc, rm, C_THRESH_B, m_b);

        chk("in_ready_idle", in_ready_a, 1'b1);
        parent_a = a;
        parent_b = b;
        in_valid = 1'b1;
        rand_in  = 8'($urandom);
        @(posedge clk); #1;                       // E0 accept
        in_valid = 1'b0;
        parent_a = 8'($urandom);
        parent_b = 8'($urandom);
        rand_in  = rc;
        chk("in_ready_cross", in_ready_a, 1'b0);
        chk("valid_cross", out_valid_a, 1'b0);
        @(posedge clk); #1;                       // E1 crossover
        rand_in = rm;
        chk("valid_mutate", out_valid_a, 1'b0);
        @(posedge clk); #1;                       // E2 mutation
        rand_in = 8'($urandom);
        chk("valid_hold", out_valid_a, 1'b1);
        chk("child", child_a, e_a);
        chk("mut_flag", mut_flag_a, m_a);
        chk("child_b", child_b, e_b);
        chk("mut_flag_b", mut_flag_b, m_b);
        chk("cnt_before", child_cnt_a, exp_cnt_a);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            parent_a = 8'($urandom);
            parent_b = 8'($urandom);
            @(posedge clk); #1;
            rand_in = 8'($urandom);
            chk("bp_child", child_a, e_a);
            chk("bp_valid", out_valid_a, 1'b1);
            chk("bp_in_ready", in_ready_a, 1'b0);
            chk("bp_cnt", child_cnt_a, exp_cnt_a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;                       // E3 delivery
        out_ready = 1'b0;
        exp_cnt_a = exp_cnt_a + 16'd1;
        exp_cnt_b = exp_cnt_b + 2'd1;
        chk("valid_done", out_valid_a, 1'b0);
        chk("cnt", child_cnt_a, exp_cnt_a);
        chk("cnt_b", child_cnt_b, exp_cnt_b);
        chk("in_ready_after", in_ready_a, 1'b1);
        chk("child_kept", child_a, e_a);
    endtask

    initial begin
        rst       = 1'b1;
        rand_in   = 8'h00;
        parent_a  = 8'h00;
        parent_b  = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_cnt_a = '0;
        exp_cnt_b = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_child", child_a, 8'h00);
        chk("rst_mut", mut_flag_a, 1'b0);
        chk("rst_valid", out_valid_a, 1'b0);
        chk("rst_cnt", child_cnt_a, 16'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready_a, 1'b1);
        @(posedge clk); #1;

        // Out_ready with nothing valid must not count.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_ready_cnt", child_cnt_a, 16'd0);

        // Directed crossover / mutation / cut boundaries.
        run_child(8'hFF, 8'h00, 8'h33, 8'h33, 0);
        run_child(8'hFF, 8'h00, 8'h03, 8'h05, 0);
        run_child(8'hFF, 8'h00, 8'h00, 8'hF0, 0);
        run_child(8'h00, 8'hFF, 8'h07, 8'hF0, 0);
        // Backpressure with new parents offered throughout.
        run_child(8'hA5, 8'h3C, 8'h04, 8'h12, 5);

        // Reset while in MUTATE.
        parent_a = 8'hFF;
        parent_b = 8'h00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rand_in  = 8'h33;
        @(posedge clk); #1;
        rand_in = 8'h05;
        rst = 1'b1;
        #1;
        chk("mrst_valid", out_valid_a, 1'b0);
        chk("mrst_child", child_a, 8'h00);
        chk("mrst_cnt", child_cnt_a, 16'd0);
        chk("mrst_in_ready", in_ready_a, 1'b0);
        exp_cnt_a = '0;
        exp_cnt_b = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_child(8'h0F, 8'hF0, 8'h05, 8'h1F, 1);

        // Random transactions, exercising counter wrap on the narrow instance.
        for (int n = 0; n < 100; n++) begin
            run_child(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ga_breeder
`default_nettype wire

// File: doc/ga_breeder.md
# ga_breeder

Offspring generator for the GA datapath, directly downstream of the LFSR random source. Accepts two 8-bit parent chromosomes over a valid/ready handshake and performs single-point crossover then probabilistic single-bit mutation, drawing one fresh random byte per stage from the LFSR output. Delivers the child chromosome over a second valid/ready handshake and keeps a running count of delivered children for the fitness/selection stage.

## Interface
- MUT_THRESH, 4'd2: mutation occurs when random nibble RAND_IN[7:4] < MUT_THRESH (unsigned); 0 disables mutation, 16 is not representable.
- CNT_W, 16: width of CHILD_CNT.
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RAND_IN  in  8  LFSR output; a new value every cycle, sampled only in CROSS and MUTATE.
- PARENT_A  in  8  first parent, sampled on input handshake.
- PARENT_B  in  8  second parent, sampled on input handshake.
- IN_VALID  in  1  parents valid.
- IN_READY  out  1  block can accept parents.
- CHILD  out  8  offspring chromosome, registered.
- MUT_FLAG  out  1  CHILD carries a mutation, registered.
- OUT_VALID  out  1  CHILD valid, registered.
- OUT_READY  in  1  consumer accepts CHILD.
- CHILD_CNT  out  CNT_W  number of children delivered since reset, wraps.

## Operation
- States: IDLE, CROSS, MUTATE, HOLD. Reset state IDLE.
- IDLE: IN_READY = 1 (forced 0 while RST high). On IN_VALID & IN_READY latch PARENT_A/B -> CROSS.
- CROSS (exactly 1 cycle): k = RAND_IN[2:0]; mask = (1 << k) - 1; child = (A & mask) | (B & ~mask). k = 0 gives child = B. -> MUTATE.
- MUTATE (exactly 1 cycle): if RAND_IN[7:4] < MUT_THRESH, flip child bit RAND_IN[2:0] and set MUT_FLAG = 1; else child unchanged, MUT_FLAG = 0. Set OUT_VALID = 1. -> HOLD.
- HOLD: CHILD, MUT_FLAG, OUT_VALID stable. On OUT_READY: OUT_VALID = 0, CHILD_CNT += 1 (mod 2^CNT_W), -> IDLE.
- IN_READY = 0 in CROSS, MUTATE, HOLD; IN_VALID ignored there.
- CHILD and MUT_FLAG keep last delivered value in IDLE/CROSS/MUTATE until overwritten at the MUTATE edge.
- RST asserted in any state: immediately state IDLE, CHILD = 0, MUT_FLAG = 0, OUT_VALID = 0, CHILD_CNT = 0, latched parents = 0; in-flight offspring discarded.

## Timing
- Input handshake at edge E0; crossover computed at E1; mutation and OUT_VALID = 1 registered at E2. OUT_VALID visible in the cycle after E2 (latency 2 edges).
- Output handshake at edge E3 (earliest); IN_READY high again after E3. Max throughput: one child per 4 cycles.
- OUT_READY low holds HOLD indefinitely; no data change while OUT_VALID high.
- The two random draws come from two consecutive LFSR values (cycles E0..E1 and E1..E2); no value reused.
- OUT_READY while OUT_VALID low has no effect.
- Reset values: IN_READY 0 during RST, 1 in the first cycle after release; all other outputs 0.

## Structure
- Shared package ga_pkg: state enum (IDLE, CROSS, MUTATE, HOLD), chromosome width constant CHROM_W = 8, crossover-mask function (k -> (1<<k)-1), mutation-flip function.
- No sub-module; single FSM plus datapath registers and counter. The LFSR is instantiated beside it at the parent level, its RAND_OUT wired to RAND_IN.

## Test plan
- Crossover: A=8'hFF, B=8'h00, RAND_IN=8'h33 in CROSS, 8'h33 in MUTATE -> k=3, no mutation, CHILD=8'h07, MUT_FLAG=0, OUT_VALID high 2 edges after accept.
- Mutation: same parents, RAND_IN=8'h03 in CROSS, 8'h05 in MUTATE -> CHILD=8'h27 (bit 5 flipped), MUT_FLAG=1.
- Cut boundaries: A=8'hFF, B=8'h00, k=0 -> 8'h00; A=8'h00, B=8'hFF, k=7 -> 8'h80 (no mutation drawn).
- Backpressure: OUT_READY low 5 cycles with IN_VALID held high and new parents -> CHILD stable, IN_READY 0, parents not latched; OUT_READY high -> CHILD_CNT 0->1, IN_READY high next cycle.
- Reset mid-operation: assert RST in MUTATE -> same cycle OUT_VALID=0, CHILD=8'h00, CHILD_CNT=0; after release first handshake runs normally.
- Counter wrap with CNT_W=2: deliver 5 children -> CHILD_CNT sequence 1,2,3,0,1; MUT_THRESH=0 -> MUT_FLAG never set across 100 random draws.
